// File: rtl/evm_ballot_unit_if.sv
// Ballot-unit signal bundle: operator controls and buttons in, tally/status out.
// The master side is the control/display path; the slave side is evm_ballot_unit.
interface evm_ballot_unit_if #(
  parameter int N_CAND = 8,
  parameter int SEL_W  = 3,
  parameter int CNT_W  = 8,
  parameter int TOT_W  = 11
);
  logic              arm;
  logic              close;
  logic [N_CAND-1:0] cand_btn;
  logic [SEL_W-1:0]  res_sel;
  logic [CNT_W-1:0]  res_count;
  logic [TOT_W-1:0]  total_count;
  logic              ready;
  logic              vote_ack;
  logic [SEL_W-1:0]  vote_idx;
  logic              reject;
  logic              sat;
  logic              timeout;
  logic              polls_closed;

  modport master (
    output arm, close, cand_btn, res_sel,
    input  res_count, total_count, ready, vote_ack, vote_idx,
           reject, sat, timeout, polls_closed
  );

  modport slave (
    input  arm, close, cand_btn, res_sel,
    output res_count, total_count, ready, vote_ack, vote_idx,
           reject, sat, timeout, polls_closed
  );
endinterface

// File: rtl/evm_ballot_unit.sv
// Ballot capture FSM with N_CAND saturating tallies, running total and readout.
// Optional arm timeout is built only when ARM_TIMEOUT_EN is defined.
module evm_ballot_unit #(
  parameter int N_CAND      = 8,
  parameter int SEL_W       = 3,
  parameter int CNT_W       = 8,
  parameter int TOT_W       = 11,
  parameter int TIMEOUT_CYC = 1000
) (
  input logic               clk,
  input logic               reset,
  evm_ballot_unit_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, ARMED, WAIT_REL, CLOSED} state_t;

  localparam int PW = $clog2(N_CAND + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [TOT_W-1:0] TOT_MAX = {TOT_W{1'b1}};

  state_t            state, state_n;
  logic [N_CAND-1:0] btn_q;
  logic [N_CAND-1:0] rise;
  logic [PW-1:0]     pop;
  logic [SEL_W-1:0]  idx;
  logic              accept, rej, fire, expire;

  logic [CNT_W-1:0]  tally [N_CAND];
  logic [CNT_W-1:0]  res_count_q;
  logic [TOT_W-1:0]  total_q;
  logic [SEL_W-1:0]  vote_idx_q;
  logic              vote_ack_q, reject_q, sat_q;

  assign rise = bus.cand_btn & ~btn_q;

  // Button count and index of the (single) pressed button.
  always_comb begin
    pop = '0;
    idx = '0;
    for (int i = 0; i < N_CAND; i++) begin
      if (bus.cand_btn[i]) begin
        pop = pop + 1'b1;
        idx = SEL_W'(i);
      end
    end
  end

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    state_n = state;
    accept  = 1'b0;
    rej     = 1'b0;
    fire    = 1'b0;
    case (state)
      IDLE:     if (bus.arm && bus.cand_btn == '0) state_n = ARMED;
      ARMED: begin
        if (rise != '0 && pop == PW'(1)) begin
          accept  = 1'b1;
          state_n = WAIT_REL;
        end else if (expire) begin
          fire    = 1'b1;
          state_n = IDLE;
        end else if (rise != '0) begin
          rej     = 1'b1;
        end
      end
      WAIT_REL: if (bus.cand_btn == '0) state_n = IDLE;
      CLOSED:   state_n = CLOSED;
      default:  state_n = IDLE;
    endcase
    // Close overrides everything, including a vote arriving in the same cycle.
    if (bus.close) begin
      state_n = CLOSED;
      accept  = 1'b0;
      rej     = 1'b0;
      fire    = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // NOTE: the tallies are flops, not RAM, so they take the async reset; no count survives reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_CAND; i++) tally[i] <= '0;
      btn_q       <= '0;
      total_q     <= '0;
      res_count_q <= '0;
      vote_idx_q  <= '0;
      vote_ack_q  <= 1'b0;
      reject_q    <= 1'b0;
      sat_q       <= 1'b0;
    end else begin
      btn_q      <= bus.cand_btn;
      vote_ack_q <= accept;
      reject_q   <= rej;
      if (accept) begin
        vote_idx_q <= idx;
        if (tally[idx] != CNT_MAX) tally[idx] <= tally[idx] + 1'b1;
        else                       sat_q      <= 1'b1;
        if (total_q != TOT_MAX)    total_q    <= total_q + 1'b1;
        else                       sat_q      <= 1'b1;
      end
      res_count_q <= (32'(bus.res_sel) < N_CAND) ? tally[bus.res_sel] : '0;
    end
  end

`ifdef ARM_TIMEOUT_EN
  localparam int TMR_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMR_W-1:0] tmr;
  logic             timeout_q;

  // Loaded on ARMED entry only; a reject leaves the countdown running.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tmr       <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= fire;
      if (state != ARMED && state_n == ARMED) tmr <= TMR_W'(TIMEOUT_CYC);
      else if (state == ARMED && tmr != '0)   tmr <= tmr - 1'b1;
    end
  end

  assign expire      = (state == ARMED) && (tmr == TMR_W'(1));
  assign bus.timeout = timeout_q;
`else
  assign expire      = 1'b0;
  assign bus.timeout = 1'b0;
`endif

  assign bus.ready        = (state == ARMED);
  assign bus.polls_closed = (state == CLOSED);
  assign bus.res_count    = res_count_q;
  assign bus.total_count  = total_q;
  assign bus.vote_ack     = vote_ack_q;
  assign bus.vote_idx     = vote_idx_q;
  assign bus.reject       = reject_q;
  assign bus.sat          = sat_q;
endmodule

// File: tb/tb_evm_ballot_unit.sv
// Directed bench for evm_ballot_unit: default instance plus a narrow 3-candidate,
// 2-bit-tally instance for saturation and out-of-range readout.
module tb_evm_ballot_unit;
  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  evm_ballot_unit_if #(.N_CAND(8), .SEL_W(3), .CNT_W(8), .TOT_W(11)) bus_a ();
  evm_ballot_unit_if #(.N_CAND(3), .SEL_W(2), .CNT_W(2), .TOT_W(3))  bus_b ();

  evm_ballot_unit #(.N_CAND(8), .SEL_W(3), .CNT_W(8), .TOT_W(11), .TIMEOUT_CYC(10)) u_dut (
    .clk(clk), .reset(reset), .bus(bus_a));

  evm_ballot_unit #(.N_CAND(3), .SEL_W(2), .CNT_W(2), .TOT_W(3), .TIMEOUT_CYC(1000)) u_sat (
    .clk(clk), .reset(reset), .bus(bus_b));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus_a.arm = 1'b0; bus_a.close = 1'b0; bus_a.cand_btn = '0; bus_a.res_sel = '0;
    bus_b.arm = 1'b0; bus_b.close = 1'b0; bus_b.cand_btn = '0; bus_b.res_sel = '0;
    repeat (2) tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (bus_a.ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %0b want 0", bus_a.ready); end
    checks++; if (bus_a.polls_closed !== 1'b0) begin errors++; $display("FAIL rst_closed: got %0b want 0", bus_a.polls_closed); end
    checks++; if (bus_a.total_count !== 11'd0) begin errors++; $display("FAIL rst_total: got %0d want 0", bus_a.total_count); end
    checks++; if (bus_a.vote_idx !== 3'd0) begin errors++; $display("FAIL rst_idx: got %0d want 0", bus_a.vote_idx); end
    checks++; if (bus_a.vote_ack !== 1'b0) begin errors++; $display("FAIL rst_ack: got %0b want 0", bus_a.vote_ack); end
    checks++; if (bus_a.reject !== 1'b0) begin errors++; $display("FAIL rst_reject: got %0b want 0", bus_a.reject); end
    checks++; if (bus_a.sat !== 1'b0) begin errors++; $display("FAIL rst_sat: got %0b want 0", bus_a.sat); end
    checks++; if (bus_a.timeout !== 1'b0) begin errors++; $display("FAIL rst_timeout: got %0b want 0", bus_a.timeout); end
    checks++; if (bus_a.res_count !== 8'd0) begin errors++; $display("FAIL rst_res: got %0d want 0", bus_a.res_count); end
  endtask

  task automatic test_single_vote();
    do_reset();
    bus_a.arm = 1'b1; tick();
    checks++; if (bus_a.ready !== 1'b1) begin errors++; $display("FAIL sv_armed: got %0b want 1", bus_a.ready); end
    bus_a.arm = 1'b0;
    bus_a.cand_btn = 8'h08; tick();
    checks++; if (bus_a.vote_ack !== 1'b1) begin errors++; $display("FAIL sv_ack: got %0b want 1", bus_a.vote_ack); end
    checks++; if (bus_a.vote_idx !== 3'd3) begin errors++; $display("FAIL sv_idx: got %0d want 3", bus_a.vote_idx); end
    checks++; if (bus_a.total_count !== 11'd1) begin errors++; $display("FAIL sv_total: got %0d want 1", bus_a.total_count); end
    checks++; if (bus_a.ready !== 1'b0) begin errors++; $display("FAIL sv_ready_fall: got %0b want 0", bus_a.ready); end
    tick();
    checks++; if (bus_a.vote_ack !== 1'b0) begin errors++; $display("FAIL sv_ack_pulse: got %0b want 0", bus_a.vote_ack); end
    tick(); tick();
    checks++; if (bus_a.total_count !== 11'd1) begin errors++; $display("FAIL sv_hold_total: got %0d want 1", bus_a.total_count); end
    bus_a.cand_btn = '0; bus_a.res_sel = 3'd3; tick();
    checks++; if (bus_a.vote_idx !== 3'd3) begin errors++; $display("FAIL sv_idx_held: got %0d want 3", bus_a.vote_idx); end
    checks++; if (bus_a.res_count !== 8'd1) begin errors++; $display("FAIL sv_tally3: got %0d want 1", bus_a.res_count); end
    bus_a.arm = 1'b1; tick();
    checks++; if (bus_a.ready !== 1'b1) begin errors++; $display("FAIL sv_rearm: got %0b want 1", bus_a.ready); end
    bus_a.arm = 1'b0;
  endtask

  task automatic test_reject();
    do_reset();
    bus_a.arm = 1'b1; tick(); bus_a.arm = 1'b0;
    bus_a.cand_btn = 8'h22; tick();
    checks++; if (bus_a.reject !== 1'b1) begin errors++; $display("FAIL rj_pulse: got %0b want 1", bus_a.reject); end
    checks++; if (bus_a.vote_ack !== 1'b0) begin errors++; $display("FAIL rj_noack: got %0b want 0", bus_a.vote_ack); end
    checks++; if (bus_a.ready !== 1'b1) begin errors++; $display("FAIL rj_ready: got %0b want 1", bus_a.ready); end
    tick();
    checks++; if (bus_a.reject !== 1'b0) begin errors++; $display("FAIL rj_one_cycle: got %0b want 0", bus_a.reject); end
    bus_a.cand_btn = '0; tick();
    bus_a.cand_btn = 8'h20; tick();
    checks++; if (bus_a.vote_ack !== 1'b1) begin errors++; $display("FAIL rj_ack5: got %0b want 1", bus_a.vote_ack); end
    checks++; if (bus_a.vote_idx !== 3'd5) begin errors++; $display("FAIL rj_idx5: got %0d want 5", bus_a.vote_idx); end
    bus_a.cand_btn = '0; bus_a.res_sel = 3'd5; tick();
    checks++; if (bus_a.res_count !== 8'd1) begin errors++; $display("FAIL rj_tally5: got %0d want 1", bus_a.res_count); end
    bus_a.res_sel = 3'd1; tick();
    checks++; if (bus_a.res_count !== 8'd0) begin errors++; $display("FAIL rj_tally1: got %0d want 0", bus_a.res_count); end
    checks++; if (bus_a.total_count !== 11'd1) begin errors++; $display("FAIL rj_total: got %0d want 1", bus_a.total_count); end
  endtask

  task automatic test_held_button();
    do_reset();
    bus_a.cand_btn = 8'h04; bus_a.arm = 1'b1; tick();
    checks++; if (bus_a.ready !== 1'b0) begin errors++; $display("FAIL hb_idle1: got %0b want 0", bus_a.ready); end
    tick();
    checks++; if (bus_a.ready !== 1'b0) begin errors++; $display("FAIL hb_idle2: got %0b want 0", bus_a.ready); end
    bus_a.cand_btn = '0; tick();
    checks++; if (bus_a.ready !== 1'b1) begin errors++; $display("FAIL hb_armed: got %0b want 1", bus_a.ready); end
    checks++; if (bus_a.total_count !== 11'd0) begin errors++; $display("FAIL hb_total: got %0d want 0", bus_a.total_count); end
    bus_a.arm = 1'b0;
  endtask

  task automatic test_close();
    do_reset();
    bus_a.arm = 1'b1; tick(); bus_a.arm = 1'b0;
    bus_a.cand_btn = 8'h10; bus_a.close = 1'b1; tick();
    checks++; if (bus_a.polls_closed !== 1'b1) begin errors++; $display("FAIL cl_closed: got %0b want 1", bus_a.polls_closed); end
    checks++; if (bus_a.vote_ack !== 1'b0) begin errors++; $display("FAIL cl_noack: got %0b want 0", bus_a.vote_ack); end
    checks++; if (bus_a.total_count !== 11'd0) begin errors++; $display("FAIL cl_total: got %0d want 0", bus_a.total_count); end
    bus_a.close = 1'b0; bus_a.cand_btn = '0; tick();
    bus_a.arm = 1'b1; tick();
    bus_a.cand_btn = 8'h10; tick();
    checks++; if (bus_a.ready !== 1'b0) begin errors++; $display("FAIL cl_noarm: got %0b want 0", bus_a.ready); end
    checks++; if (bus_a.vote_ack !== 1'b0) begin errors++; $display("FAIL cl_noack2: got %0b want 0", bus_a.vote_ack); end
    bus_a.res_sel = 3'd4; tick();
    checks++; if (bus_a.res_count !== 8'd0) begin errors++; $display("FAIL cl_tally4: got %0d want 0", bus_a.res_count); end
    checks++; if (bus_a.polls_closed !== 1'b1) begin errors++; $display("FAIL cl_terminal: got %0b want 1", bus_a.polls_closed); end
    bus_a.arm = 1'b0; bus_a.cand_btn = '0;
    reset = 1'b1; #1;
    checks++; if (bus_a.polls_closed !== 1'b0) begin errors++; $display("FAIL cl_async_rst: got %0b want 0", bus_a.polls_closed); end
    tick(); reset = 1'b0; tick();
  endtask

  task automatic test_reset_mid_ballot();
    do_reset();
    bus_a.arm = 1'b1; tick(); bus_a.arm = 1'b0;
    bus_a.cand_btn = 8'h40; tick();
    bus_a.cand_btn = '0; tick();
    bus_a.arm = 1'b1; tick(); bus_a.arm = 1'b0;
    bus_a.cand_btn = 8'h40; #2; reset = 1'b1; tick();
    checks++; if (bus_a.vote_ack !== 1'b0) begin errors++; $display("FAIL rm_noack: got %0b want 0", bus_a.vote_ack); end
    checks++; if (bus_a.total_count !== 11'd0) begin errors++; $display("FAIL rm_total: got %0d want 0", bus_a.total_count); end
    checks++; if (bus_a.ready !== 1'b0) begin errors++; $display("FAIL rm_ready: got %0b want 0", bus_a.ready); end
    reset = 1'b0; bus_a.cand_btn = '0; bus_a.res_sel = 3'd6; tick();
    checks++; if (bus_a.res_count !== 8'd0) begin errors++; $display("FAIL rm_tally6: got %0d want 0", bus_a.res_count); end
  endtask

  task automatic test_saturation();
    int exp_tally, exp_total;
    logic exp_sat;
    do_reset();
    for (int v = 1; v <= 8; v++) begin
      exp_tally = (v < 3) ? v : 3;
      exp_total = (v < 7) ? v : 7;
      exp_sat   = (v >= 4);
      bus_b.arm = 1'b1; tick(); bus_b.arm = 1'b0;
      bus_b.cand_btn = 3'b001; tick();
      checks++; if (bus_b.vote_ack !== 1'b1) begin errors++; $display("FAIL sat_ack v%0d: got %0b want 1", v, bus_b.vote_ack); end
      bus_b.cand_btn = '0; bus_b.res_sel = 2'd0; tick();
      checks++; if (bus_b.res_count !== 2'(exp_tally)) begin errors++; $display("FAIL sat_tally v%0d: got %0d want %0d", v, bus_b.res_count, exp_tally); end
      checks++; if (bus_b.total_count !== 3'(exp_total)) begin errors++; $display("FAIL sat_total v%0d: got %0d want %0d", v, bus_b.total_count, exp_total); end
      checks++; if (bus_b.sat !== exp_sat) begin errors++; $display("FAIL sat_flag v%0d: got %0b want %0b", v, bus_b.sat, exp_sat); end
    end
    bus_b.res_sel = 2'd3; tick();
    checks++; if (bus_b.res_count !== 2'd0) begin errors++; $display("FAIL sat_oor: got %0d want 0", bus_b.res_count); end
  endtask

`ifdef ARM_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    bus_a.arm = 1'b1; tick(); bus_a.arm = 1'b0;
    repeat (9) tick();
    checks++; if (bus_a.ready !== 1'b1) begin errors++; $display("FAIL to_still_armed: got %0b want 1", bus_a.ready); end
    checks++; if (bus_a.timeout !== 1'b0) begin errors++; $display("FAIL to_early: got %0b want 0", bus_a.timeout); end
    tick();
    checks++; if (bus_a.timeout !== 1'b1) begin errors++; $display("FAIL to_pulse: got %0b want 1", bus_a.timeout); end
    checks++; if (bus_a.ready !== 1'b0) begin errors++; $display("FAIL to_ready: got %0b want 0", bus_a.ready); end
    tick();
    checks++; if (bus_a.timeout !== 1'b0) begin errors++; $display("FAIL to_one_cycle: got %0b want 0", bus_a.timeout); end
    bus_a.cand_btn = 8'h01; tick();
    checks++; if (bus_a.vote_ack !== 1'b0) begin errors++; $display("FAIL to_noack: got %0b want 0", bus_a.vote_ack); end
    checks++; if (bus_a.total_count !== 11'd0) begin errors++; $display("FAIL to_total: got %0d want 0", bus_a.total_count); end
    bus_a.cand_btn = '0; tick();
  endtask
`else
  task automatic test_no_timeout();
    do_reset();
    bus_a.arm = 1'b1; tick(); bus_a.arm = 1'b0;
    repeat (15) tick();
    checks++; if (bus_a.ready !== 1'b1) begin errors++; $display("FAIL nt_armed: got %0b want 1", bus_a.ready); end
    checks++; if (bus_a.timeout !== 1'b0) begin errors++; $display("FAIL nt_timeout: got %0b want 0", bus_a.timeout); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_vote();
    test_reject();
    test_held_button();
    test_close();
    test_reset_mid_ballot();
    test_saturation();
`ifdef ARM_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
